// File: rtl/clmul_gf2_serial.sv
// Digit-serial GF(2) carry-less multiplier with optional reduction modulo {1,POLY}.
// Multiplies LSB-digit first, then folds the upper half back MSB first, DIGIT bits per cycle.
module clmul_gf2_serial #(
    parameter int           N     = 8,
    parameter int           DIGIT = 2,
    parameter logic [N-1:0] POLY  = N'(8'h1B)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           reduce,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out
);

    localparam int              K     = N / DIGIT;
    localparam int              CW    = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0]   LAST  = CW'(K - 1);
    localparam logic [2*N-1:0]  PFULL = {{(N-1){1'b0}}, 1'b1, POLY};

    typedef enum logic [1:0] {IDLE, MUL, RED, DONE} state_t;

    state_t         r_state;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_ash;
    logic [N-1:0]   r_bsh;
    logic           r_reduce;
    logic [CW-1:0]  r_cnt;
    logic           r_in_ready;
    logic           r_out_valid;

    logic [2*N-1:0] w_mul_acc;
    logic [2*N-1:0] w_red_acc;
    logic           w_last;

    // Partial product of the (pre-shifted) A against one digit of B.
    function automatic logic [2*N-1:0] clmul_digit(input logic [2*N-1:0] x,
                                                   input logic [DIGIT-1:0] d);
        logic [2*N-1:0] p;
        p = '0;
        for (int k = 0; k < DIGIT; k++) begin
            if (d[k]) p = p ^ (x << k);
        end
        return p;
    endfunction

    // Fold one digit of the upper half; bits are handled top-down so a fold
    // that sets a lower bit inside the same digit is seen by that bit.
    function automatic logic [2*N-1:0] red_digit(input logic [2*N-1:0] x,
                                                 input logic [CW-1:0]  c);
        logic [2*N-1:0] p;
        p = x;
        for (int j = 2*N-1; j >= N; j--) begin
            if (((2*N-1-j) / DIGIT) == int'(c) && p[j]) p = p ^ (PFULL << (j - N));
        end
        return p;
    endfunction

    assign w_mul_acc = r_acc ^ clmul_digit(r_ash, r_bsh[DIGIT-1:0]);
    assign w_red_acc = red_digit(r_acc, r_cnt);
    assign w_last    = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_ash       <= '0;
            r_bsh       <= '0;
            r_reduce    <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_ash      <= {{N{1'b0}}, a};
                        r_bsh      <= b;
                        r_reduce   <= reduce;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= MUL;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                MUL: begin
                    r_acc <= w_mul_acc;
                    r_ash <= r_ash << DIGIT;
                    r_bsh <= r_bsh >> DIGIT;
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_reduce) begin
                            r_state <= RED;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RED: begin
                    r_acc <= w_red_acc;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The accumulator is left untouched until the next acceptance, so the
    // last result stays visible in IDLE.
    assign out       = r_acc;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_clmul_gf2_serial.sv
// Bench for clmul_gf2_serial: directed vectors on N=8/DIGIT=2 plus a random
// scoreboard run on both the N=8 and the N=16/DIGIT=4 configurations.
module tb_clmul_gf2_serial;

    localparam int NB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [NB-1:0]         iv, ordy, red, ir, ov;
    logic [NB-1:0][15:0]   a_s, b_s;
    logic [NB-1:0][31:0]   o_s;
    logic [15:0]           out8;
    logic [31:0]           out16;

    assign o_s = {out16, 16'h0000, out8};

    clmul_gf2_serial #(.N(8), .DIGIT(2), .POLY(8'h1B)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_s[0][7:0]), .b(b_s[0][7:0]), .reduce(red[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out(out8)
    );

    clmul_gf2_serial #(.N(16), .DIGIT(4), .POLY(16'h002B)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_s[1]), .b(b_s[1]), .reduce(red[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out(out16)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: polynomial product and long division over GF(2).
    function automatic logic [31:0] m_clmul(input logic [15:0] x, input logic [15:0] y, input int n);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < n; i++) begin
            if (y[i]) p = p ^ (32'(x) << i);
        end
        return p;
    endfunction

    function automatic logic [31:0] m_mod(input logic [31:0] p, input int n, input logic [15:0] poly);
        logic [31:0] full, r;
        full = (32'd1 << n) | 32'(poly);
        r    = p;
        for (int j = 2*n-1; j >= n; j--) begin
            if (r[j]) r = r ^ (full << (j - n));
        end
        return r;
    endfunction

    function automatic int m_n(input int d);
        return (d == 0) ? 8 : 16;
    endfunction

    function automatic logic [15:0] m_poly(input int d);
        return (d == 0) ? 16'h001B : 16'h002B;
    endfunction

    // Transaction-level model: expected handshake levels and result per DUT.
    logic [NB-1:0] m_init  = '0;
    logic [NB-1:0] m_ready = '0;
    logic [NB-1:0] m_valid = '0;
    logic [NB-1:0] m_known = '0;
    int            m_left [NB] = '{0, 0};
    int            m_done [NB] = '{0, 0};
    logic [31:0]   m_out  [NB] = '{32'h0, 32'h0};
    logic [31:0]   m_res  [NB] = '{32'h0, 32'h0};

    always @(posedge clk) begin
        for (int d = 0; d < NB; d++) begin
            if (!rst_n) begin
                m_init[d]  = 1'b1;
                m_ready[d] = 1'b0;
                m_valid[d] = 1'b0;
                m_left[d]  = 0;
                m_out[d]   = '0;
                m_known[d] = 1'b1;
            end else if (m_init[d]) begin
                if (m_ready[d] && iv[d]) begin
                    logic [15:0] xa, xb;
                    xa = a_s[d] & 16'((32'd1 << m_n(d)) - 1);
                    xb = b_s[d] & 16'((32'd1 << m_n(d)) - 1);
                    m_ready[d] = 1'b0;
                    m_known[d] = 1'b0;
                    m_left[d]  = red[d] ? 8 : 4;
                    m_res[d]   = red[d] ? m_mod(m_clmul(xa, xb, m_n(d)), m_n(d), m_poly(d))
                                        : m_clmul(xa, xb, m_n(d));
                end else if (m_left[d] > 0) begin
                    m_left[d]--;
                    if (m_left[d] == 0) begin
                        m_valid[d] = 1'b1;
                        m_out[d]   = m_res[d];
                        m_known[d] = 1'b1;
                    end
                end else if (m_valid[d]) begin
                    if (ordy[d]) begin
                        m_valid[d] = 1'b0;
                        m_ready[d] = 1'b1;
                        m_done[d]++;
                    end
                end else begin
                    m_ready[d] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < NB; d++) begin
            if (m_init[d]) begin
                chk($sformatf("dut%0d.in_ready", d), 32'(ir[d]), 32'(m_ready[d]));
                chk($sformatf("dut%0d.out_valid", d), 32'(ov[d]), 32'(m_valid[d]));
                if (m_known[d]) chk($sformatf("dut%0d.out", d), o_s[d], m_out[d]);
            end
        end
    end

    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic r,
                          input logic [15:0] exp, input int lat, input string nm);
        int t;
        t = 0;
        while (!ir[0] && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk({nm, ".in_ready"}, 32'(ir[0]), 32'd1);
        a_s[0] = {8'h00, xa};
        b_s[0] = {8'h00, xb};
        red[0] = r;
        iv[0]  = 1'b1;
        @(posedge clk); #1;
        iv[0]  = 1'b0;
        a_s[0] = 16'h00A5;
        b_s[0] = 16'h005A;
        red[0] = ~r;
        t = 0;
        while (!ov[0] && t < 40) begin
            @(posedge clk); #1; t++;
        end
        chk({nm, ".latency"}, 32'(t), 32'(lat));
        chk({nm, ".out"}, o_s[0], {16'h0000, exp});
        chk({nm, ".model"}, m_out[0], {16'h0000, exp});
    endtask

    task automatic take_result();
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
    endtask

    initial begin
        int cyc, base0, base1;
        rst_n = 1'b0;
        iv = '0; ordy = '0; red = '0; a_s = '0; b_s = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.in_ready", 32'(ir[0]), 32'd0);
        chk("reset.out_valid", 32'(ov[0]), 32'd0);
        chk("reset.out", o_s[0], 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release.in_ready", 32'(ir[0]), 32'd1);

        run_op(8'h57, 8'h83, 1'b0, 16'h2B79, 4, "mul57"); take_result();
        run_op(8'h57, 8'h83, 1'b1, 16'h00C1, 8, "red57"); take_result();
        run_op(8'hFF, 8'hFF, 1'b0, 16'h5555, 4, "mulFF"); take_result();
        run_op(8'h02, 8'h87, 1'b1, 16'h0015, 8, "red02"); take_result();
        run_op(8'h00, 8'h00, 1'b0, 16'h0000, 4, "zero_mul"); take_result();
        run_op(8'h00, 8'h00, 1'b1, 16'h0000, 8, "zero_red"); take_result();

        // Backpressure in DONE with a stray operand pulse.
        run_op(8'h57, 8'h83, 1'b0, 16'h2B79, 4, "bp");
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                iv[0] = 1'b1; a_s[0] = 16'h0011; b_s[0] = 16'h0022;
            end
            @(posedge clk); #1;
            iv[0] = 1'b0;
            chk("bp.out", o_s[0], 32'h2B79);
            chk("bp.out_valid", 32'(ov[0]), 32'd1);
            chk("bp.in_ready", 32'(ir[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("bp.release.out_valid", 32'(ov[0]), 32'd0);
        chk("bp.release.in_ready", 32'(ir[0]), 32'd1);
        chk("bp.release.out", o_s[0], 32'h2B79);

        // Reset on the second MUL edge abandons the operation.
        a_s[0] = 16'h0057; b_s[0] = 16'h0083; red[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst.out_valid", 32'(ov[0]), 32'd0);
        chk("midrst.out", o_s[0], 32'h0);
        chk("midrst.in_ready", 32'(ir[0]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst.release.in_ready", 32'(ir[0]), 32'd1);
        run_op(8'h00, 8'hAB, 1'b0, 16'h0000, 4, "after_rst"); take_result();

        // Random mixed-mode traffic with backpressure on both configurations.
        base0 = m_done[0];
        base1 = m_done[1];
        cyc = 0;
        while ((m_done[0] - base0 < 1000 || m_done[1] - base1 < 1000) && cyc < 60000) begin
            for (int d = 0; d < NB; d++) begin
                iv[d]   = ($urandom_range(0, 2) != 0);
                a_s[d]  = (d == 0) ? {8'h00, 8'($urandom)} : 16'($urandom);
                b_s[d]  = (d == 0) ? {8'h00, 8'($urandom)} : 16'($urandom);
                red[d]  = 1'($urandom_range(0, 1));
                ordy[d] = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("rand.dut0_ops", 32'(m_done[0] - base0 >= 1000), 32'd1);
        chk("rand.dut1_ops", 32'(m_done[1] - base1 >= 1000), 32'd1);

        iv = '0;
        ordy = '1;
        repeat (12) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/clmul_gf2_serial.md
CLMUL_GF2_SERIAL -- requirements
Module: clmul_gf2_serial

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits; legal range N >= 2.
REQ-002 SHALL have parameter DIGIT, default 2: B bits consumed per cycle; 1 <= DIGIT <= N; N % DIGIT == 0.
REQ-003 SHALL have parameter POLY, default 8'h1B: low N bits of the reduction polynomial, with x^N implicit.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-008 SHALL have port a, input, N bits: operand A, a GF(2) polynomial.
REQ-009 SHALL have port b, input, N bits: operand B, a GF(2) polynomial.
REQ-010 SHALL have port reduce, input, 1 bit: mode select; 1 = reduce the result modulo {1,POLY}.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port out, output, 2N bits: the carry-less product, or the reduced remainder zero-extended to 2N bits.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, RED and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-016 SHALL accept operands on an edge with in_valid & in_ready; at that edge it captures a, b and reduce, clears the accumulator and the digit counter, and moves IDLE->MUL.
REQ-017 SHALL ignore any change on a, b or reduce after acceptance, and SHALL ignore in_valid while not in IDLE.
REQ-018 SHALL, in MUL, XOR (A clmul digit_i) << (i*DIGIT) into a 2N-bit accumulator each cycle, for i = 0..K-1 LSB-digit first, where K = N/DIGIT.
REQ-019 SHALL, after the K-th MUL cycle, move to DONE if reduce = 0, else to RED.
REQ-020 SHALL, in RED, process accumulator bits 2N-1 down to N, DIGIT bits per cycle in K cycles, highest bit first; for each set bit j it XORs {1,POLY} << (j-N) into the accumulator, with earlier updates visible to later bits in the same cycle.
REQ-021 SHALL, after the K-th RED cycle, move to DONE with accumulator bits 2N-1..N equal to 0.
REQ-022 SHALL fix latency at K edges (reduce = 0) or 2K edges (reduce = 1) from the acceptance edge to out_valid = 1; the default parameters give 4 or 8 edges.
REQ-023 SHALL, in DONE, hold out stable and out_valid high until out_valid & out_ready; at that edge it moves to IDLE.
REQ-024 SHALL produce no same-edge restart: in_ready rises the cycle after the output handshake.
REQ-025 SHALL make out equal to the accumulator in DONE; out SHALL also hold its last value in IDLE.
REQ-026 SHALL produce a correct result for all-zero operands: out = 0 in both modes, with unchanged latency.
REQ-027 SHALL implement all arithmetic as XOR only, with no carries; the maximum product degree is 2N-2, so out[2N-1] = 0 always.

Reset
REQ-028 SHALL, on any edge with rst_n = 0, enter IDLE and clear the accumulator, the digit counter and the captured operands, giving out = 0, out_valid = 0 and in_ready = 0 during reset.
REQ-029 SHALL give in_ready = 1 on the first cycle after rst_n returns high.
REQ-030 SHALL, if reset occurs mid-operation (MUL, RED or DONE), discard the operation with no output handshake.

Verification (N=8, DIGIT=2, POLY=8'h1B)
REQ-031 SHALL cover: a=8'h57, b=8'h83, reduce=0 -> out=16'h2B79 exactly 4 edges after acceptance.
REQ-032 SHALL cover: a=8'h57, b=8'h83, reduce=1 -> out=16'h00C1 exactly 8 edges after acceptance.
REQ-033 SHALL cover: a=8'hFF, b=8'hFF, reduce=0 -> out=16'h5555; then a=8'h02, b=8'h87, reduce=1 -> out=16'h0015.
REQ-034 SHALL cover: out_ready held low 5 cycles in DONE -> out and out_valid stable, in_ready=0, and an in_valid pulse with new operands ignored; out_ready=1 -> IDLE next edge.
REQ-035 SHALL cover: rst_n low for one edge during MUL cycle 2 -> out_valid=0, out=0; after release in_ready=1, and the next operation a=8'h00, b=8'hAB gives out=0.
REQ-036 SHALL cover a random scoreboard of 1000 operations in mixed modes under random backpressure, compared against a reference carry-less multiply and mod-{1,POLY} model, also run at N=16 and DIGIT=4.
